seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/seq_control_unit.sv | 108 ++++++++++
 tb/tb_seq_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer that fetches instructions, branches locally and hands ALU work to an external execute unit
//   clk, rst_n              : rising-edge clock, synchronous active-low reset
//   run                     : start pulse, restarts at pc 0 from IDLE or HALT
//   imem_addr/imem_rd       : instruction fetch request; imem_rdata returns one cycle later
//   ex_valid/ex_ready       : execute request handshake carrying ex_op, ex_a, ex_b
//   ex_rvalid/ex_result     : execute result, written to reg[W] while waiting for it
//   host_we/host_addr/wdata : register preload while IDLE or HALT; dbg_rdata reads reg[host_addr]
//   pc, busy, halted        : status
module seq_control_unit #(
   parameter int OP_W   = 5,
   parameter int ADDR_W = 5,
   parameter int WORD_W = OP_W + 3*ADDR_W,
   parameter int PC_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_rd,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [OP_W-1:0]   ex_op,
   output logic [WORD_W-1:0] ex_a,
   output logic [WORD_W-1:0] ex_b,
   input  logic              ex_rvalid,
   input  logic [WORD_W-1:0] ex_result,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [WORD_W-1:0] host_wdata,
   output logic [WORD_W-1:0] dbg_rdata,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted
);
   localparam int REG_CNT = 2**ADDR_W;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT_R, HALT} state_t;
   state_t state, state_nx;
   logic [WORD_W-1:0] regs [REG_CNT];
   logic [WORD_W-1:0] ir;
   logic [OP_W-1:0]   op;
   logic [ADDR_W-1:0] fa, fb, fw, ir_w;
   logic idle, is_nop, is_brz, is_halt, is_alu, take, wb, unused_ir;
   // decode works straight off the fetched word; ir keeps it for the write-back address
   assign op        = imem_rdata[OP_W-1:0];
   assign fa        = imem_rdata[OP_W +: ADDR_W];
   assign fb        = imem_rdata[OP_W+ADDR_W +: ADDR_W];
   assign fw        = imem_rdata[OP_W+2*ADDR_W +: ADDR_W];
   assign ir_w      = ir[OP_W+2*ADDR_W +: ADDR_W];
   assign unused_ir = ^ir[OP_W+2*ADDR_W-1:0];
   assign is_nop    = op == '0;
   assign is_brz    = op == OP_W'(1);
   assign is_halt   = op == '1;
   assign is_alu    = !is_nop && !is_brz && !is_halt;
   assign take      = is_brz && regs[fa] == '0;
   assign idle      = state == IDLE || state == HALT;
   assign wb        = state == WAIT_R && ex_rvalid;
   assign imem_addr = pc;
   assign imem_rd   = state == FETCH;
   assign ex_valid  = state == EXEC;
   assign busy      = !idle;
   assign halted    = state == HALT;
   assign dbg_rdata = regs[host_addr];
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, HALT: state_nx = run ? FETCH : state;
         FETCH:      state_nx = DECODE;
         DECODE:     state_nx = is_halt ? HALT : is_alu ? EXEC : FETCH;
         EXEC:       state_nx = ex_ready ? WAIT_R : EXEC;
         WAIT_R:     state_nx = ex_rvalid ? FETCH : WAIT_R;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc    <= '0;
         ir    <= '0;
         ex_op <= '0;
         ex_a  <= '0;
         ex_b  <= '0;
      end else begin
         if (idle && run) pc <= '0;
         else if (state == DECODE && take) pc <= PC_W'(fw);
         else if ((state == DECODE && (is_nop || is_brz)) || wb) pc <= pc + 1'b1;
         if (state == DECODE) ir <= imem_rdata;
         if (state == DECODE && is_alu) begin
            ex_op <= op;
            ex_a  <= regs[fa];
            ex_b  <= regs[fb];
         end
      end
   end
   // host writes and result write-back live in disjoint states, so they never collide
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      end else if (idle && host_we) begin
         regs[host_addr] <= host_wdata;
      end else if (wb) begin
         regs[ir_w] <= ex_result;
      end
   end
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: scoreboard bench with an instruction-level reference model of seq_control_unit
module tb_seq_control_unit;
   localparam int OP_W = 5, ADDR_W = 5, WORD_W = 20, PC_W = 5;
   localparam int EXW = OP_W + 2*WORD_W;
   logic clk = 0, rst_n = 0, run = 0;
   logic [PC_W-1:0] imem_addr, pc;
   logic imem_rd, ex_valid, ex_ready = 0, ex_rvalid = 0, host_we = 0, busy, halted;
   logic [WORD_W-1:0] imem_rdata = '0, ex_a, ex_b, ex_result = '0, host_wdata = '0, dbg_rdata;
   logic [OP_W-1:0] ex_op;
   logic [ADDR_W-1:0] host_addr = '0;
   always #5 clk = ~clk;
   seq_control_unit #(.OP_W(OP_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .imem_rdata(imem_rdata), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_a(ex_a), .ex_b(ex_b), .ex_rvalid(ex_rvalid), .ex_result(ex_result),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .dbg_rdata(dbg_rdata), .pc(pc), .busy(busy), .halted(halted));

   int n_vec = 0, n_bad = 0;
   logic [WORD_W-1:0] imem [32];
   logic [WORD_W-1:0] mregs [32];
   logic [PC_W-1:0] exp_fetch [$];
   logic [EXW-1:0] exp_ex [$];
   logic [PC_W-1:0] exp_pc;
   bit hold = 0, fast = 0;
   int force_need = -1;
   int last_hold = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] alu(input logic [OP_W-1:0] op, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
      return (op == 5'd2) ? a + b : (a ^ b) + WORD_W'(op);
   endfunction

   function automatic logic [WORD_W-1:0] ins(input int op, input int a, input int b, input int w);
      return {5'(w), 5'(b), 5'(a), 5'(op)};
   endfunction

   // instruction-level model: walks the program once and queues every fetch and execute request
   task automatic iss();
      logic [PC_W-1:0] p;
      logic [WORD_W-1:0] w;
      int op, a, b, wf;
      p = '0;
      exp_fetch.delete();
      exp_ex.delete();
      for (int s = 0; s < 2000; s++) begin
         exp_fetch.push_back(p);
         w = imem[p];
         op = int'(w) % 32;
         a = (int'(w) / 32) % 32;
         b = (int'(w) / 1024) % 32;
         wf = (int'(w) / 32768) % 32;
         if (op == 31) break;
         if (op == 1 && mregs[a] == 0) p = PC_W'(wf);
         else begin
            if (op >= 2) begin
               exp_ex.push_back({5'(op), mregs[a], mregs[b]});
               mregs[wf] = alu(5'(op), mregs[a], mregs[b]);
            end
            p = PC_W'((int'(p) + 1) % 32);
         end
      end
      exp_pc = p;
   endtask

   // execute unit and instruction memory, driven just after each rising edge
   bit rd_pend = 0, res_pend = 0;
   logic [PC_W-1:0] rd_addr = '0;
   logic [WORD_W-1:0] res_val = '0;
   int res_cnt = 0, ex_wait = 0, cur_need = 0;
   initial forever begin
      @(posedge clk); #1;
      imem_rdata = rd_pend ? imem[rd_addr] : WORD_W'($urandom);
      if (ex_valid !== 1'b1) begin
         ex_wait = 0;
         cur_need = force_need >= 0 ? force_need : fast ? 0 : int'($urandom_range(0, 3));
      end
      ex_ready = (ex_valid === 1'b1) ? (!hold && ex_wait >= cur_need) : 1'($urandom_range(0, 1));
      if (res_pend && res_cnt == 0) begin
         ex_rvalid = 1;
         ex_result = res_val;
         res_pend = 0;
      end else if (res_pend) begin
         ex_rvalid = 0;
         ex_result = WORD_W'($urandom);
         res_cnt--;
      end else begin
         ex_rvalid = (imem_rd === 1'b1) || $urandom_range(0, 3) == 0;
         ex_result = WORD_W'($urandom);
      end
      rd_pend = imem_rd === 1'b1;
      rd_addr = imem_addr;
      if (ex_valid === 1'b1 && ex_ready) begin
         res_pend = 1;
         res_cnt = fast ? 0 : int'($urandom_range(0, 2));
         res_val = alu(ex_op, ex_a, ex_b);
      end else if (ex_valid === 1'b1) ex_wait++;
      if (!rst_n) res_pend = 0;
   end

   // monitor: compares whatever the DUT presents against the scoreboard queues
   bit prev_valid = 0, prev_acc = 0;
   logic [OP_W-1:0] prev_op;
   logic [WORD_W-1:0] prev_a, prev_b;
   logic [EXW-1:0] e;
   int val_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_rd) begin
            if (exp_fetch.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL fetch_extra: got address %0d, expected no fetch", imem_addr);
            end else chk("fetch_addr", 32'(imem_addr), 32'(exp_fetch.pop_front()));
         end
         if (ex_valid) begin
            val_cnt++;
            if (prev_valid && !prev_acc) begin
               chk("hold_op", 32'(ex_op), 32'(prev_op));
               chk("hold_a", 32'(ex_a), 32'(prev_a));
               chk("hold_b", 32'(ex_b), 32'(prev_b));
            end
            if (ex_ready) begin
               if (exp_ex.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL ex_extra: got op %0d, expected no request", ex_op);
               end else begin
                  e = exp_ex.pop_front();
                  chk("ex_op", 32'(ex_op), 32'(e[EXW-1 -: OP_W]));
                  chk("ex_a", 32'(ex_a), 32'(e[2*WORD_W-1 -: WORD_W]));
                  chk("ex_b", 32'(ex_b), 32'(e[WORD_W-1:0]));
               end
               last_hold = val_cnt;
            end
         end else val_cnt = 0;
         prev_valid = ex_valid;
         prev_acc = ex_valid && ex_ready;
         prev_op = ex_op;
         prev_a = ex_a;
         prev_b = ex_b;
      end else prev_valid = 0;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_halted"}, 32'(halted), 0);
      chk({tag, "_pc"}, 32'(pc), 0);
      chk({tag, "_ex_valid"}, 32'(ex_valid), 0);
      chk({tag, "_imem_rd"}, 32'(imem_rd), 0);
      chk({tag, "_ex_op"}, 32'(ex_op), 0);
      chk({tag, "_ex_a"}, 32'(ex_a), 0);
      chk({tag, "_ex_b"}, 32'(ex_b), 0);
   endtask

   task automatic do_reset();
      rst_n = 0; run = 0; host_we = 0;
      tick(); tick();
      check_reset_state("reset");
      rst_n = 1;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      exp_fetch.delete();
      exp_ex.delete();
   endtask

   task automatic host_write(input int a, input logic [WORD_W-1:0] d);
      host_we = 1; host_addr = ADDR_W'(a); host_wdata = d;
      tick();
      host_we = 0;
      mregs[a] = d;
   endtask

   task automatic dump_regs(input string tag);
      for (int i = 0; i < 32; i++) begin
         host_addr = ADDR_W'(i);
         #1;
         chk({tag, "_reg"}, 32'(dbg_rdata), 32'(mregs[i]));
      end
      tick();
   endtask

   task automatic run_prog(input string tag, input bit noise, output int cyc);
      iss();
      run = 1;
      cyc = 0;
      forever begin
         tick();
         cyc++;
         host_we = 0; run = 0;
         if (halted || cyc > 3000) break;
         if (noise && busy) begin
            host_we = 1'($urandom_range(0, 1));
            host_addr = ADDR_W'($urandom);
            host_wdata = WORD_W'($urandom);
            run = 1'($urandom_range(0, 1));
         end
      end
      chk({tag, "_halted"}, 32'(halted), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
      chk({tag, "_fetch_left"}, exp_fetch.size(), 0);
      chk({tag, "_ex_left"}, exp_ex.size(), 0);
      dump_regs(tag);
   endtask

   int cyc, len, k;
   initial begin
      for (int i = 0; i < 32; i++) imem[i] = WORD_W'($urandom);
      do_reset();
      // single ALU instruction at minimum latency, then HALT
      host_write(3, 5);
      host_write(4, 7);
      imem[0] = ins(2, 3, 4, 6);
      imem[1] = ins(31, 0, 0, 0);
      fast = 1;
      run_prog("basic", 0, cyc);
      chk("basic_cycles", cyc, 7);
      chk("basic_final_pc", 32'(pc), 1);
      host_addr = 6; #1;
      chk("basic_r6", 32'(dbg_rdata), 12);
      fast = 0;
      tick();
      // execute unit stalls three cycles before accepting
      force_need = 3;
      imem[0] = ins(5, 3, 4, 7);
      run_prog("stall", 0, cyc);
      chk("stall_valid_cycles", last_hold, 4);
      force_need = -1;
      // branch taken and not taken
      host_write(5, 0);
      host_write(6, 1);
      imem[0] = ins(1, 5, 0, 9);
      imem[9] = ins(1, 6, 0, 20);
      imem[10] = ins(31, 0, 0, 0);
      run_prog("brz", 1, cyc);
      chk("brz_final_pc", 32'(pc), 10);
      // pc wraps from 31 to 0 after a NOP
      host_write(1, 0);
      host_write(2, 3);
      imem[0] = ins(1, 1, 0, 30);
      imem[30] = ins(2, 2, 2, 1);
      imem[31] = ins(0, 0, 0, 0);
      imem[1] = ins(31, 0, 0, 0);
      run_prog("wrap", 1, cyc);
      chk("wrap_final_pc", 32'(pc), 1);
      // host write while busy is ignored, then reset mid-handshake
      host_write(3, 20'hABC);
      imem[0] = ins(4, 3, 3, 1);
      imem[1] = ins(31, 0, 0, 0);
      hold = 1;
      iss();
      run = 1;
      tick();
      run = 0;
      for (int i = 0; i < 20 && !ex_valid; i++) tick();
      chk("stuck_ex_valid", 32'(ex_valid), 1);
      host_we = 1; host_addr = 3; host_wdata = 20'h12345;
      tick();
      host_we = 0;
      chk("busy_we_ignored", 32'(dbg_rdata), 20'hABC);
      rst_n = 0;
      tick();
      check_reset_state("mid_exec_reset");
      chk("mid_exec_reset_reg3", 32'(dbg_rdata), 0);
      rst_n = 1;
      hold = 0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      tick();
      run_prog("post_reset", 0, cyc);
      // randomized programs with forward-only branches so every program halts
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 32; i++) host_write(i, $urandom_range(0, 1) ? '0 : WORD_W'($urandom));
         len = $urandom_range(3, 24);
         for (int i = 0; i < 32; i++) imem[i] = WORD_W'($urandom);
         for (int i = 0; i < len - 1; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0) imem[i] = ins(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            else if (k == 1) imem[i] = ins(1, $urandom_range(0, 31), 0, $urandom_range(i + 1, len - 1));
            else imem[i] = ins($urandom_range(2, 30), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
         end
         imem[len-1] = ins(31, 0, 0, 0);
         run_prog("random", 1, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
